rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- In-order retirement end of the rename pipeline.
- Rename pushes one entry per cycle into this reorder buffer. Each entry holds the arch rd, the new physical reg and the previous mapping (old prd).
- Writeback on the common data bus marks entries done. The head retires in order, returns the old prd to the free list, and drives the committed-RAT update.
- An excepting head triggers a flush plus youngest-first rollback that frees every squashed new prd, so no physical register leaks.

Parameters:
- DEPTH, 16, ROB entries (power of 2).
- IDX_W, 4, log2(DEPTH); width of ROB tags.
- PREG_W, 6, physical register address width.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- alloc_valid_i  in  1  rename pushes an entry.
- alloc_ready_o  out  1  entry slot available.
- alloc_rd_we_i  in  1  instruction writes a register.
- alloc_rd_addr_i  in  5  arch destination.
- alloc_prd_i  in  PREG_W  newly allocated physical dest.
- alloc_old_prd_i  in  PREG_W  previous RAT mapping of rd.
- alloc_pc_i  in  32  instruction PC.
- alloc_tag_o  out  IDX_W  tag given to the entry accepted this cycle (equals tail pointer).
- cdb_en_i  in  1  completion broadcast.
- cdb_tag_i  in  IDX_W  completing entry.
- cdb_exc_i  in  1  completion raised an exception.
- commit_valid_o  out  1  one-cycle retire pulse.
- commit_rd_we_o  out  1  retired entry writes rd.
- commit_rd_addr_o  out  5  arch rd of retired entry.
- commit_prd_o  out  PREG_W  prd to install in the committed RAT.
- free_en_o  out  1  return a physical reg to the free list.
- free_addr_o  out  PREG_W  physical reg being freed.
- flush_o  out  1  one-cycle pipeline flush pulse.
- flush_pc_o  out  32  PC of the excepting instruction.
- busy_o  out  1  rollback in progress.

Behaviour:
- Storage:
  - Circular buffer with head, tail and count (IDX_W+1 bits).
  - Per entry: valid, done, exc, rd_we, rd, prd, old_prd, pc.
- Reset (async, reset_i=0):
  - head=tail=count=0; all valid/done/exc bits cleared; state=RUN.
  - All registered outputs are 0.
  - A reset asserted mid-rollback abandons the walk; no further frees are issued.
- alloc_ready_o = (state==RUN) && (count<DEPTH). It is combinational and does NOT consider a same-cycle retire.
- Allocation:
  - Occurs on an edge with alloc_valid_i && alloc_ready_o.
  - Writes the entry at tail with done=0, exc=0, then tail+1 with wrap mod DEPTH.
- CDB:
  - When cdb_en_i and state==RUN, the entry at cdb_tag_i sets done=1 and exc=cdb_exc_i.
  - A CDB hit on an invalid entry is ignored.
  - A CDB in the same cycle as allocation of that tag is illegal (undefined).
- Retire (RUN):
  - Condition: head valid && done && !exc. Head clears valid, head+1.
  - Next cycle (registered): commit_valid_o=1, commit_rd_we_o/rd_addr/prd from the entry.
  - Also next cycle: free_en_o=rd_we && old_prd!=0, free_addr_o=old_prd. Physical reg 0 is never freed.
  - At most one retire per cycle.
  - A done bit written at edge E is retirable at edge E+1 (no CDB-to-retire bypass).
- Simultaneous alloc and retire: count unchanged, both pointers advance.
- Exception:
  - Trigger: head valid && done && exc in RUN.
  - Next edge: state=ROLLBACK, flush_o=1 for exactly one cycle, flush_pc_o=head pc. No commit pulse.
  - Allocations are not accepted on that edge (alloc_ready_o already 0 once state changes; alloc on the trigger edge itself is still accepted and later squashed).
- ROLLBACK (busy_o=1, CDB ignored, alloc_ready_o=0):
  - Each edge pops the youngest entry (tail-1): tail-1, count-1, valid cleared.
  - Registered free_en_o=rd_we && prd!=0, free_addr_o=prd (the NEW prd). The excepting head entry is included.
  - When count reaches 0, state=RUN on the same edge.
  - Total rollback edges = entries held at entry to ROLLBACK.
- Outputs commit_*, free_*, flush_* are registers. Pulse signals deassert the cycle after unless re-asserted.

Test Plan:
- Reset, push 3 entries (rd 1,2,3; prd 32,33,34; old 1,2,3); CDB tags 0,1,2 in order -> three commit pulses, free_addr_o 1,2,3 on consecutive cycles; count returns to 0.
- Out-of-order completion: CDB tag 2 then 1 then 0 -> no commit until tag 0 done; then commits in tag order 0,1,2 on back-to-back cycles.
- Fill 16 entries -> alloc_ready_o=0 with count=16. Retire head while alloc_valid_i=1 -> alloc refused that cycle, accepted the next. Tail wraps to 0 and alloc_tag_o=0.
- Entry with rd_we=0 or old_prd=0 retires -> commit_valid_o=1, free_en_o=0.
- 4 entries (prd 40..43, rd_we=1), CDB tag 0 with exc=1, pc 0x100 -> flush_o one cycle with flush_pc_o=0x100, busy_o high 4 cycles, free_addr_o 43,42,41,40, then alloc_ready_o=1.
- Async reset asserted mid-rollback (after 2 frees) -> outputs 0 immediately, no further frees; after release the buffer is empty with alloc_tag_o=0.

Source files
------------

// File: rtl/rob_commit.sv
// rob_commit: in-order retirement end of the rename pipeline.
//
// Rename pushes one entry per cycle into a circular reorder buffer. Each
// entry remembers the arch rd, the newly allocated physical register and the
// previous mapping of rd. Writeback on the CDB marks entries done. The head
// retires in order: it drives the committed-RAT update and returns the old
// prd to the free list. An excepting head flushes the pipeline and then walks
// the buffer youngest-first, freeing every squashed new prd so that no
// physical register leaks.
//
// Ports:
//   clk_i, reset_i              clock (rising edge), async active-low reset
//   alloc_*                     rename push interface; alloc_tag_o = tail
//   cdb_en_i/cdb_tag_i/cdb_exc_i completion broadcast
//   commit_*                    registered one-cycle retire pulse + payload
//   free_en_o/free_addr_o       registered free-list return
//   flush_o/flush_pc_o          registered one-cycle flush pulse + PC
//   busy_o                      high while the rollback walk is running
module rob_commit #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  input  logic              alloc_rd_we_i,
  input  logic [4:0]        alloc_rd_addr_i,
  input  logic [PREG_W-1:0] alloc_prd_i,
  input  logic [PREG_W-1:0] alloc_old_prd_i,
  input  logic [31:0]       alloc_pc_i,
  output logic [IDX_W-1:0]  alloc_tag_o,
  input  logic              cdb_en_i,
  input  logic [IDX_W-1:0]  cdb_tag_i,
  input  logic              cdb_exc_i,
  output logic              commit_valid_o,
  output logic              commit_rd_we_o,
  output logic [4:0]        commit_rd_addr_o,
  output logic [PREG_W-1:0] commit_prd_o,
  output logic              free_en_o,
  output logic [PREG_W-1:0] free_addr_o,
  output logic              flush_o,
  output logic [31:0]       flush_pc_o,
  output logic              busy_o
);

  typedef enum logic {
    RUN      = 1'b0,
    ROLLBACK = 1'b1
  } state_e;

  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e state_q, state_d;

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] exc_q, exc_d;

  logic [DEPTH-1:0]  rd_we_q, rd_we_d;
  logic [4:0]        rd_q      [DEPTH];
  logic [4:0]        rd_d      [DEPTH];
  logic [PREG_W-1:0] prd_q     [DEPTH];
  logic [PREG_W-1:0] prd_d     [DEPTH];
  logic [PREG_W-1:0] old_prd_q [DEPTH];
  logic [PREG_W-1:0] old_prd_d [DEPTH];
  logic [31:0]       pc_q      [DEPTH];
  logic [31:0]       pc_d      [DEPTH];

  logic              commit_valid_q, commit_valid_d;
  logic              commit_rd_we_q, commit_rd_we_d;
  logic [4:0]        commit_rd_addr_q, commit_rd_addr_d;
  logic [PREG_W-1:0] commit_prd_q, commit_prd_d;
  logic              free_en_q, free_en_d;
  logic [PREG_W-1:0] free_addr_q, free_addr_d;
  logic              flush_q, flush_d;
  logic [31:0]       flush_pc_q, flush_pc_d;

  logic             alloc_fire;
  logic             head_retire;
  logic             head_exc;
  logic [IDX_W-1:0] pop_idx;

  assign alloc_fire  = alloc_valid_i && alloc_ready_o;
  assign head_retire = (state_q == RUN) && valid_q[head_q] && done_q[head_q] && !exc_q[head_q];
  assign head_exc    = (state_q == RUN) && valid_q[head_q] && done_q[head_q] && exc_q[head_q];
  // Rollback always removes the youngest entry, which sits just below tail.
  assign pop_idx     = tail_q - IDX_ONE;

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enter rollback on an excepting head, leave it on the
  // edge that pops the last remaining entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (head_exc) begin
          state_d = ROLLBACK;
        end
      end
      ROLLBACK: begin
        if (count_q <= CNT_ONE) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // FSM outputs. Ready deliberately ignores a same-cycle retire.
  always_comb begin
    alloc_ready_o = (state_q == RUN) && (count_q < CNT_FULL);
    busy_o        = (state_q == ROLLBACK);
  end

  assign alloc_tag_o = tail_q;

  // Buffer datapath. In RUN the CDB, retire/exception and allocation all act
  // on the same edge; the head decision uses the pre-edge done bit, so a
  // completion is retirable one edge after it is written. In ROLLBACK the
  // youngest entry is popped each edge and its new prd is freed.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    valid_d   = valid_q;
    done_d    = done_q;
    exc_d     = exc_q;
    rd_we_d   = rd_we_q;
    rd_d      = rd_q;
    prd_d     = prd_q;
    old_prd_d = old_prd_q;
    pc_d      = pc_q;

    commit_valid_d   = 1'b0;
    commit_rd_we_d   = commit_rd_we_q;
    commit_rd_addr_d = commit_rd_addr_q;
    commit_prd_d     = commit_prd_q;
    free_en_d        = 1'b0;
    free_addr_d      = free_addr_q;
    flush_d          = 1'b0;
    flush_pc_d       = flush_pc_q;

    if (state_q == RUN) begin
      if (cdb_en_i && valid_q[cdb_tag_i]) begin
        done_d[cdb_tag_i] = 1'b1;
        exc_d[cdb_tag_i]  = cdb_exc_i;
      end

      if (head_retire) begin
        valid_d[head_q]  = 1'b0;
        head_d           = head_q + IDX_ONE;
        commit_valid_d   = 1'b1;
        commit_rd_we_d   = rd_we_q[head_q];
        commit_rd_addr_d = rd_q[head_q];
        commit_prd_d     = prd_q[head_q];
        // Physical register 0 is hardwired and never returned.
        free_en_d        = rd_we_q[head_q] && (old_prd_q[head_q] != '0);
        free_addr_d      = old_prd_q[head_q];
      end else if (head_exc) begin
        flush_d    = 1'b1;
        flush_pc_d = pc_q[head_q];
      end

      if (alloc_fire) begin
        valid_d[tail_q]   = 1'b1;
        done_d[tail_q]    = 1'b0;
        exc_d[tail_q]     = 1'b0;
        rd_we_d[tail_q]   = alloc_rd_we_i;
        rd_d[tail_q]      = alloc_rd_addr_i;
        prd_d[tail_q]     = alloc_prd_i;
        old_prd_d[tail_q] = alloc_old_prd_i;
        pc_d[tail_q]      = alloc_pc_i;
        tail_d            = tail_q + IDX_ONE;
      end

      count_d = count_q + {{IDX_W{1'b0}}, alloc_fire} - {{IDX_W{1'b0}}, head_retire};
    end else if (count_q != '0) begin
      valid_d[pop_idx] = 1'b0;
      tail_d           = pop_idx;
      count_d          = count_q - CNT_ONE;
      free_en_d        = rd_we_q[pop_idx] && (prd_q[pop_idx] != '0);
      free_addr_d      = prd_q[pop_idx];
    end
  end

  // Control state and registered outputs; reset abandons any rollback walk.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      valid_q          <= '0;
      done_q           <= '0;
      exc_q            <= '0;
      commit_valid_q   <= 1'b0;
      commit_rd_we_q   <= 1'b0;
      commit_rd_addr_q <= '0;
      commit_prd_q     <= '0;
      free_en_q        <= 1'b0;
      free_addr_q      <= '0;
      flush_q          <= 1'b0;
      flush_pc_q       <= '0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      valid_q          <= valid_d;
      done_q           <= done_d;
      exc_q            <= exc_d;
      commit_valid_q   <= commit_valid_d;
      commit_rd_we_q   <= commit_rd_we_d;
      commit_rd_addr_q <= commit_rd_addr_d;
      commit_prd_q     <= commit_prd_d;
      free_en_q        <= free_en_d;
      free_addr_q      <= free_addr_d;
      flush_q          <= flush_d;
      flush_pc_q       <= flush_pc_d;
    end
  end

  // Entry payload is only meaningful while valid, so it needs no reset.
  always_ff @(posedge clk_i) begin
    rd_we_q   <= rd_we_d;
    rd_q      <= rd_d;
    prd_q     <= prd_d;
    old_prd_q <= old_prd_d;
    pc_q      <= pc_d;
  end

  assign commit_valid_o   = commit_valid_q;
  assign commit_rd_we_o   = commit_rd_we_q;
  assign commit_rd_addr_o = commit_rd_addr_q;
  assign commit_prd_o     = commit_prd_q;
  assign free_en_o        = free_en_q;
  assign free_addr_o      = free_addr_q;
  assign flush_o          = flush_q;
  assign flush_pc_o       = flush_pc_q;

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: self-checking bench for rob_commit. A queue-based reference
// model of the reorder buffer predicts every registered output; directed
// steps exercise in-order retirement, full/wrap behaviour, exception rollback
// and reset during rollback, followed by a randomized phase.
module tb_rob_commit;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int PREG_W = 6;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b0;
  logic              alloc_valid_i = 1'b0;
  logic              alloc_ready_o;
  logic              alloc_rd_we_i = 1'b0;
  logic [4:0]        alloc_rd_addr_i = '0;
  logic [PREG_W-1:0] alloc_prd_i = '0;
  logic [PREG_W-1:0] alloc_old_prd_i = '0;
  logic [31:0]       alloc_pc_i = '0;
  logic [IDX_W-1:0]  alloc_tag_o;
  logic              cdb_en_i = 1'b0;
  logic [IDX_W-1:0]  cdb_tag_i = '0;
  logic              cdb_exc_i = 1'b0;
  logic              commit_valid_o;
  logic              commit_rd_we_o;
  logic [4:0]        commit_rd_addr_o;
  logic [PREG_W-1:0] commit_prd_o;
  logic              free_en_o;
  logic [PREG_W-1:0] free_addr_o;
  logic              flush_o;
  logic [31:0]       flush_pc_o;
  logic              busy_o;

  rob_commit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_rd_we_i(alloc_rd_we_i), .alloc_rd_addr_i(alloc_rd_addr_i),
    .alloc_prd_i(alloc_prd_i), .alloc_old_prd_i(alloc_old_prd_i),
    .alloc_pc_i(alloc_pc_i), .alloc_tag_o(alloc_tag_o),
    .cdb_en_i(cdb_en_i), .cdb_tag_i(cdb_tag_i), .cdb_exc_i(cdb_exc_i),
    .commit_valid_o(commit_valid_o), .commit_rd_we_o(commit_rd_we_o),
    .commit_rd_addr_o(commit_rd_addr_o), .commit_prd_o(commit_prd_o),
    .free_en_o(free_en_o), .free_addr_o(free_addr_o),
    .flush_o(flush_o), .flush_pc_o(flush_pc_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          tag;
    bit          we;
    logic [4:0]  rd;
    logic [5:0]  prd;
    logic [5:0]  old;
    logic [31:0] pc;
    bit          done;
    bit          exc;
  } ent_t;

  // Reference model: program-order queue, oldest at index 0.
  ent_t        mq[$];
  int          m_tail;
  bit          m_rb;
  bit          e_cv, e_cwe, e_fe, e_fl;
  logic [4:0]  e_crd;
  logic [5:0]  e_cprd, e_fa;
  logic [31:0] e_fpc;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;
  logic [5:0] seen_free[$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    m_rb   = 1'b0;
    e_cv = 0; e_cwe = 0; e_fe = 0; e_fl = 0;
    e_crd = '0; e_cprd = '0; e_fa = '0; e_fpc = '0;
  endtask

  // One clock edge of the reference model, using the inputs held this cycle.
  task automatic model_step();
    bit   ready;
    ent_t e;
    ready = !m_rb && (mq.size() < DEPTH);
    e_cv = 0; e_fe = 0; e_fl = 0;
    if (!m_rb) begin
      if (mq.size() > 0 && mq[0].done) begin
        if (!mq[0].exc) begin
          e_cv = 1; e_cwe = mq[0].we; e_crd = mq[0].rd; e_cprd = mq[0].prd;
          e_fe = mq[0].we && (mq[0].old != 0);
          e_fa = mq[0].old;
          mq.delete(0);
        end else begin
          e_fl  = 1;
          e_fpc = mq[0].pc;
          m_rb  = 1;
        end
      end
      if (cdb_en_i) begin
        foreach (mq[i]) begin
          if (mq[i].tag == int'(cdb_tag_i)) begin
            mq[i].done = 1;
            mq[i].exc  = cdb_exc_i;
          end
        end
      end
      if (alloc_valid_i && ready) begin
        e = '{tag: m_tail, we: alloc_rd_we_i, rd: alloc_rd_addr_i, prd: alloc_prd_i,
              old: alloc_old_prd_i, pc: alloc_pc_i, done: 0, exc: 0};
        mq.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end else begin
      if (mq.size() > 0) begin
        e = mq[mq.size()-1];
        mq.delete(mq.size()-1);
        e_fe   = e.we && (e.prd != 0);
        e_fa   = e.prd;
        m_tail = (m_tail + DEPTH - 1) % DEPTH;
      end
      if (mq.size() == 0) m_rb = 0;
    end
  endtask

  task automatic compare_outputs();
    check("commit_valid", commit_valid_o, e_cv);
    if (e_cv) begin
      check("commit_rd_we", commit_rd_we_o, e_cwe);
      check("commit_rd_addr", commit_rd_addr_o, e_crd);
      check("commit_prd", commit_prd_o, e_cprd);
    end
    check("free_en", free_en_o, e_fe);
    if (e_fe) check("free_addr", free_addr_o, e_fa);
    check("flush", flush_o, e_fl);
    if (e_fl) check("flush_pc", flush_pc_o, e_fpc);
    check("busy", busy_o, m_rb);
    check("alloc_ready", alloc_ready_o, !m_rb && (mq.size() < DEPTH));
    check("alloc_tag", alloc_tag_o, m_tail);
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (!reset_i) model_reset();
    else model_step();
    @(negedge clk_i);
    compare_outputs();
    if (free_en_o) seen_free.push_back(free_addr_o);
  endtask

  task automatic clear_inputs();
    alloc_valid_i = 0; alloc_rd_we_i = 0; alloc_rd_addr_i = '0;
    alloc_prd_i = '0; alloc_old_prd_i = '0; alloc_pc_i = '0;
    cdb_en_i = 0; cdb_tag_i = '0; cdb_exc_i = 0;
  endtask

  task automatic set_alloc(input bit we, input int rd, input int prd, input int old, input int pc);
    alloc_valid_i = 1; alloc_rd_we_i = we; alloc_rd_addr_i = 5'(rd);
    alloc_prd_i = 6'(prd); alloc_old_prd_i = 6'(old); alloc_pc_i = 32'(pc);
  endtask

  task automatic push(input bit we, input int rd, input int prd, input int old, input int pc);
    set_alloc(we, rd, prd, old, pc);
    tick();
    clear_inputs();
  endtask

  task automatic cdb(input int tag, input bit exc);
    cdb_en_i = 1; cdb_tag_i = 4'(tag); cdb_exc_i = exc;
    tick();
    clear_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Complete every outstanding entry oldest-first and let the buffer drain.
  task automatic complete_all();
    int idx;
    for (int guard = 0; guard < 80 && mq.size() > 0; guard++) begin
      idx = -1;
      foreach (mq[i]) if (idx < 0 && !mq[i].done) idx = i;
      if (idx >= 0) cdb(mq[idx].tag, 0);
      else tick();
    end
    if (mq.size() != 0) begin
      total_cnt++;
      fail_cnt++;
      $error("FAIL drain_timeout: observed %0d entries expected 0", mq.size());
    end
  endtask

  initial begin
    int busy_cycles;
    int flush_cycles;
    int n_free;
    int cand[$];
    model_reset();
    clear_inputs();

    // Reset state.
    idle(2);
    check("rst_commit_valid", commit_valid_o, 0);
    check("rst_free_en", free_en_o, 0);
    check("rst_free_addr", free_addr_o, 0);
    check("rst_flush", flush_o, 0);
    check("rst_flush_pc", flush_pc_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_alloc_tag", alloc_tag_o, 0);
    reset_i = 1;
    tick();

    // Three entries completed in order retire on consecutive cycles.
    seen_free.delete();
    for (int i = 0; i < 3; i++) push(1, i + 1, 32 + i, i + 1, 'h10 + 4 * i);
    for (int i = 0; i < 3; i++) cdb(i, 0);
    idle(3);
    check("inorder_nfree", seen_free.size(), 3);
    for (int i = 0; i < 3 && i < seen_free.size(); i++) check("inorder_free_addr", seen_free[i], i + 1);

    // Out-of-order completion retires in tag order only once the head is done.
    for (int i = 0; i < 3; i++) push(1, 4 + i, 35 + i, 4 + i, 'h20 + 4 * i);
    cdb(5, 0);
    cdb(4, 0);
    idle(1);
    check("ooo_no_commit", commit_valid_o, 0);
    cdb(3, 0);
    idle(4);

    // Fill to 16 entries; tail wraps through tag 0.
    for (int i = 0; i < 16; i++) begin
      if (i == 10) check("wrap_tag", alloc_tag_o, 0);
      push(i % 5 != 0, i + 1, i + 16, (i % 4 == 0) ? 0 : i + 1, 'h40 + 4 * i);
    end
    check("full_ready", alloc_ready_o, 0);
    cdb(mq[0].tag, 0);
    set_alloc(1, 7, 60, 7, 'h80);
    tick();
    check("refused_during_retire_tag", alloc_tag_o, 6);
    tick();
    check("accepted_next_tag", alloc_tag_o, 7);
    clear_inputs();
    complete_all();
    idle(3);

    // Exception at the head: flush, then youngest-first rollback of 4 entries.
    seen_free.delete();
    for (int i = 0; i < 4; i++) push(1, 10 + i, 40 + i, 20 + i, 'h100 + 4 * i);
    cdb(mq[0].tag, 1);
    busy_cycles = 0;
    flush_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy_o) busy_cycles++;
      if (flush_o) begin
        flush_cycles++;
        check("exc_flush_pc", flush_pc_o, 'h100);
      end
    end
    check("exc_busy_cycles", busy_cycles, 4);
    check("exc_flush_cycles", flush_cycles, 1);
    check("exc_nfree", seen_free.size(), 4);
    for (int i = 0; i < 4 && i < seen_free.size(); i++) check("exc_free_addr", seen_free[i], 43 - i);
    check("exc_ready_after", alloc_ready_o, 1);

    // Reset asserted mid-rollback abandons the walk.
    seen_free.delete();
    for (int i = 0; i < 4; i++) push(1, 14 + i, 50 + i, 24 + i, 'h200 + 4 * i);
    cdb(mq[0].tag, 1);
    for (int i = 0; i < 10 && seen_free.size() < 2; i++) tick();
    check("midrb_nfree_before", seen_free.size(), 2);
    #2 reset_i = 0;
    #1;
    model_reset();
    check("midrb_free_en", free_en_o, 0);
    check("midrb_busy", busy_o, 0);
    check("midrb_flush", flush_o, 0);
    check("midrb_commit", commit_valid_o, 0);
    check("midrb_alloc_tag", alloc_tag_o, 0);
    idle(2);
    reset_i = 1;
    idle(3);
    check("midrb_nfree_after", seen_free.size(), 2);
    check("midrb_tag_after", alloc_tag_o, 0);
    check("midrb_ready_after", alloc_ready_o, 1);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom % 4 != 0)
        set_alloc($urandom % 4 != 0, $urandom_range(0, 31), $urandom_range(0, 63),
                  ($urandom % 4 == 0) ? 0 : $urandom_range(1, 63), $urandom);
      cand.delete();
      foreach (mq[i]) if (!mq[i].done) cand.push_back(mq[i].tag);
      if (cand.size() > 0 && $urandom % 3 != 0) begin
        cdb_en_i  = 1;
        cdb_tag_i = 4'(cand[$urandom_range(0, cand.size() - 1)]);
        cdb_exc_i = ($urandom % 16 == 0);
      end
      tick();
      clear_inputs();
    end
    n_free = seen_free.size();
    idle(20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
